ldm_writeback_seq: RTL

LDM_WRITEBACK_SEQ -- requirements
Module: ldm_writeback_seq

---
 rtl/ldm_writeback_seq_pkg.sv | 14 +
 rtl/ldm_writeback_seq_encoder.sv | 23 ++
 rtl/ldm_writeback_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ldm_writeback_seq_pkg.sv
// Shared definitions for the load-multiple writeback sequencer: state encoding and default word stride.
package ldm_writeback_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_WBASE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned ADDR_STEP_DEFAULT = 4;

endpackage

// File: rtl/ldm_writeback_seq_encoder.sv
// Lowest-set-bit index and population count of a 16-bit register mask.
module lsb_encoder16 (
  input  logic [15:0] mask_i,
  output logic [3:0]  index_o,
  output logic [4:0]  count_o,
  output logic        valid_o
);

  always_comb begin
    index_o = 4'd0;
    count_o = 5'd0;
    // Descending scan so the last hit is the lowest set bit.
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) index_o = 4'(i);
    end
    for (int i = 0; i < 16; i++) begin
      count_o = count_o + 5'(mask_i[i]);
    end
  end

  assign valid_o = |mask_i;

endmodule

// File: rtl/ldm_writeback_seq.sv
// Load-multiple sequencer: reads consecutive words, writes them to the register file
// lowest register first, then optionally writes the updated base register.
module ldm_writeback_seq
  import ldm_writeback_seq_pkg::*;
#(
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] reg_list,
  input  logic [31:0] base_addr,
  input  logic [3:0]  base_reg,
  input  logic        up,
  input  logic        wback,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        reg_write,
  output logic [3:0]  write_addr,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] STEP_W = 32'(ADDR_STEP);

  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [3:0]  base_reg_q, base_reg_d;
  logic        do_wb_q, do_wb_d;
  logic        mem_req_q, mem_req_d;
  logic        reg_write_q, reg_write_d;
  logic [3:0]  write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] enc_mask;
  logic [3:0]  enc_index;
  logic [4:0]  enc_count;
  logic        enc_valid;
  logic [31:0] offset;

  // In IDLE the encoder sizes the incoming list; afterwards it walks the remaining mask.
  assign enc_mask = (state_q == ST_IDLE) ? reg_list : mask_q;
  assign offset   = STEP_W * {27'd0, enc_count};

  lsb_encoder16 u_enc (
    .mask_i  (enc_mask),
    .index_o (enc_index),
    .count_o (enc_count),
    .valid_o (enc_valid)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    wb_val_d     = wb_val_q;
    base_reg_d   = base_reg_q;
    do_wb_d      = do_wb_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (enc_valid) begin
            state_d    = ST_READ;
            mask_d     = reg_list;
            base_reg_d = base_reg;
            do_wb_d    = wback & ~reg_list[base_reg];
            wb_val_d   = up ? (base_addr + offset) : (base_addr - offset);
            addr_d     = up ? base_addr : (base_addr - offset);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        if (mem_ready) begin
          state_d      = ST_WRITE;
          write_addr_d = enc_index;
          write_data_d = mem_rdata;
        end
      end
      ST_WRITE: begin
        mask_d = mask_q & ~(16'd1 << enc_index);
        if (mask_d != 16'd0) begin
          state_d = ST_READ;
          addr_d  = addr_q + STEP_W;
        end else if (do_wb_q) begin
          state_d      = ST_WBASE;
          write_addr_d = base_reg_q;
          write_data_d = wb_val_q;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WBASE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered copies decoded from the state being entered.
    mem_req_d   = (state_d == ST_READ);
    reg_write_d = (state_d == ST_WRITE) || (state_d == ST_WBASE);
    busy_d      = (state_d == ST_READ) || (state_d == ST_WRITE) || (state_d == ST_WBASE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mask_q       <= 16'd0;
      addr_q       <= 32'd0;
      wb_val_q     <= 32'd0;
      base_reg_q   <= 4'd0;
      do_wb_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      write_addr_q <= 4'd0;
      write_data_q <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      wb_val_q     <= wb_val_d;
      base_reg_q   <= base_reg_d;
      do_wb_q      <= do_wb_d;
      mem_req_q    <= mem_req_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
